// File: rtl/sram_port_arbiter.sv
// Arbitrates one single-port SRAM between a read-only fetch port (I) and a read/write data port (D).
// D has fixed priority; I is forced through after MAX_WAIT consecutive contended losses.
module sram_port_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned MAX_WAIT   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req_valid,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  output logic                  i_req_ready,
  output logic                  i_rsp_valid,
  output logic [DATA_WIDTH-1:0] i_rsp_data,
  input  logic                  d_req_valid,
  input  logic                  d_req_we,
  input  logic [ADDR_WIDTH-1:0] d_req_addr,
  input  logic [DATA_WIDTH-1:0] d_req_wdata,
  output logic                  d_req_ready,
  output logic                  d_rsp_valid,
  output logic [DATA_WIDTH-1:0] d_rsp_data,
  output logic                  sram_csb,
  output logic                  sram_web,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_din,
  input  logic [DATA_WIDTH-1:0] sram_dout
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  owner_e           owner_q, owner_d;
  logic             we_q, we_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             i_gnt, d_gnt, wait_full;

  // Grant: D by default, I once it has lost MAX_WAIT contended cycles in a row.
  always_comb begin
    wait_full = (wait_cnt_q == CNT_W'(MAX_WAIT));
    i_gnt     = 1'b0;
    d_gnt     = 1'b0;
    if (!rst) begin
      if (d_req_valid && !(i_req_valid && wait_full)) begin
        d_gnt = 1'b1;
      end else if (i_req_valid) begin
        i_gnt = 1'b1;
      end
    end
  end

  assign i_req_ready = i_gnt;
  assign d_req_ready = d_gnt;

  // SRAM drive in the grant cycle; the macro registers these on the next rising edge.
  always_comb begin
    sram_csb  = 1'b1;
    sram_web  = 1'b1;
    sram_addr = '0;
    sram_din  = '0;
    if (d_gnt) begin
      sram_csb  = 1'b0;
      sram_web  = ~d_req_we;
      sram_addr = d_req_addr;
      sram_din  = d_req_wdata;
    end else if (i_gnt) begin
      sram_csb  = 1'b0;
      sram_addr = i_req_addr;
    end
  end

  // Next-state: response owner/we for the cycle after issue, and I starvation counter.
  always_comb begin
    owner_d    = OWN_NONE;
    we_d       = 1'b0;
    wait_cnt_d = wait_cnt_q;
    if (d_gnt) begin
      owner_d = OWN_D;
      we_d    = d_req_we;
    end else if (i_gnt) begin
      owner_d = OWN_I;
    end
    if (!i_req_valid || i_gnt) begin
      wait_cnt_d = '0;
    end else if (d_gnt && !wait_full) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q    <= OWN_NONE;
      we_q       <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      owner_q    <= owner_d;
      we_q       <= we_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Responses read the macro output directly; gated so nothing but valid data leaves the block.
  assign i_rsp_valid = !rst && (owner_q == OWN_I);
  assign d_rsp_valid = !rst && (owner_q == OWN_D);
  assign i_rsp_data  = i_rsp_valid ? sram_dout : '0;
  assign d_rsp_data  = (d_rsp_valid && !we_q) ? sram_dout : '0;

endmodule
